// File: rtl/demux_1x2_64bit_s2_pkg.sv
// Shared select encodings and route decode for the 1:2 64-bit demux.
package demux_1x2_64bit_s2_pkg;

   localparam int unsigned        SEL_W = 2;
   localparam logic [SEL_W-1:0]   SEL_A = 2'b00;
   localparam logic [SEL_W-1:0]   SEL_B = 2'b11;

   typedef enum logic [1:0] {
      ROUTE_A,
      ROUTE_B,
      ROUTE_DROP
   } route_e;

   // 01/10 are illegal selects; those words are accepted and discarded.
   function automatic route_e decode_sel(input logic [SEL_W-1:0] sel);
      case (sel)
         SEL_A:   return ROUTE_A;
         SEL_B:   return ROUTE_B;
         default: return ROUTE_DROP;
      endcase
   endfunction

endpackage

// File: rtl/demux_1x2_64bit_s2_fifo.sv
// Registered synchronous FIFO: no bypass, push blocked when full even if popping.
module fifo_sync_64bit #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == OCC_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + OCC_W'(1);
         2'b01:   count_d = count_q - OCC_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= din;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/demux_1x2_64bit_s2.sv
// 1:2 valid/ready demux with a registered FIFO per output and a saturating drop counter.
module demux_1x2_64bit_s2
   import demux_1x2_64bit_s2_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0] in_sel,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [WIDTH-1:0] b_data,
   output logic             sel_err,
   output logic [CNT_W-1:0] drop_cnt
);

   route_e           route;
   logic             full_a, full_b, empty_a, empty_b;
   logic             push_a, push_b, drop;
   logic             sel_err_q, sel_err_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Ready depends only on select and fullness, never on in_valid or the consumer readies.
   always_comb begin
      route    = decode_sel(in_sel);
      in_ready = 1'b1;
      case (route)
         ROUTE_A: in_ready = !full_a;
         ROUTE_B: in_ready = !full_b;
         default: in_ready = 1'b1;
      endcase
      push_a = in_valid && in_ready && (route == ROUTE_A);
      push_b = in_valid && in_ready && (route == ROUTE_B);
      drop   = in_valid && (route == ROUTE_DROP);
   end

   always_comb begin
      sel_err_d  = drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_err_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         sel_err_q  <= sel_err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign sel_err  = sel_err_q;
   assign drop_cnt = drop_cnt_q;
   assign a_valid  = !empty_a;
   assign b_valid  = !empty_b;

   fifo_sync_64bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_a),
      .din     (in_data),
      .pop     (a_valid && a_ready),
      .full    (full_a),
      .empty   (empty_a),
      .dout    (a_data)
   );

   fifo_sync_64bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_b),
      .din     (in_data),
      .pop     (b_valid && b_ready),
      .full    (full_b),
      .empty   (empty_b),
      .dout    (b_data)
   );

endmodule

// File: tb/tb_demux_1x2_64bit_s2.sv
// Directed self-checking bench for demux_1x2_64bit_s2.
module tb_demux_1x2_64bit_s2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [1:0]  in_sel;
   logic        a_valid, a_ready;
   logic [63:0] a_data;
   logic        b_valid, b_ready;
   logic [63:0] b_data;
   logic        sel_err;
   logic [7:0]  drop_cnt;

   int passed = 0;
   int total  = 0;

   demux_1x2_64bit_s2 #(.WIDTH(64), .DEPTH(2), .CNT_W(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .sel_err  (sel_err),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      in_valid = 1'b1;
      in_data  = 64'd99;
      in_sel   = 2'b00;
      a_ready  = 1'b0;
      b_ready  = 1'b0;
      step(); step();
      total++; if (a_valid !== 1'b0) $display("FAIL reset_a_valid: got %b expected 0", a_valid); else passed++;
      total++; if (b_valid !== 1'b0) $display("FAIL reset_b_valid: got %b expected 0", b_valid); else passed++;
      total++; if (sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b expected 0", sel_err); else passed++;
      total++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else passed++;
      total++; if (a_data !== 64'd0) $display("FAIL reset_a_data: got %0h expected 0", a_data); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_ready_a: got %b expected 1", in_ready); else passed++;
      in_sel = 2'b11; #1;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_ready_b: got %b expected 1", in_ready); else passed++;
      in_valid = 1'b0;
      #2 reset_n = 1'b1;
      step();
   endtask

   task automatic test_route_a();
      a_ready = 1'b1; in_valid = 1'b1; in_sel = 2'b00; in_data = 64'd1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL route_a_ready: got %b expected 1", in_ready); else passed++;
      step();
      in_valid = 1'b0;
      total++; if (a_valid !== 1'b1) $display("FAIL route_a_valid: got %b expected 1", a_valid); else passed++;
      total++; if (a_data !== 64'd1) $display("FAIL route_a_data: got %0h expected 1", a_data); else passed++;
      total++; if (b_valid !== 1'b0) $display("FAIL route_a_b_quiet: got %b expected 0", b_valid); else passed++;
      step();
      total++; if (a_valid !== 1'b0) $display("FAIL route_a_drained: got %b expected 0", a_valid); else passed++;
      a_ready = 1'b0;
   endtask

   task automatic test_route_b();
      b_ready = 1'b1; in_valid = 1'b1; in_sel = 2'b11; in_data = 64'd2;
      step();
      in_valid = 1'b0;
      total++; if (b_valid !== 1'b1) $display("FAIL route_b_valid: got %b expected 1", b_valid); else passed++;
      total++; if (b_data !== 64'd2) $display("FAIL route_b_data: got %0h expected 2", b_data); else passed++;
      total++; if (a_valid !== 1'b0) $display("FAIL route_b_a_quiet: got %b expected 0", a_valid); else passed++;
      step();
      total++; if (b_valid !== 1'b0) $display("FAIL route_b_drained: got %b expected 0", b_valid); else passed++;
      b_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      b_ready = 1'b0; a_ready = 1'b0;
      in_valid = 1'b1; in_sel = 2'b11; in_data = 64'd10;
      step();
      in_data = 64'd11;
      step();
      in_data = 64'd12;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_full_b_ready: got %b expected 0", in_ready); else passed++;
      in_sel = 2'b00; in_data = 64'd5;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_a_open: got %b expected 1", in_ready); else passed++;
      step();
      total++; if (a_data !== 64'd5) $display("FAIL bp_a_data: got %0h expected 5", a_data); else passed++;
      // B full with a pop pending: push must still be refused this cycle.
      b_ready = 1'b1; in_sel = 2'b11; in_data = 64'd12;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_full_pop_ready: got %b expected 0", in_ready); else passed++;
      total++; if (b_data !== 64'd10) $display("FAIL bp_b_first: got %0h expected a", b_data); else passed++;
      step();
      total++; if (b_data !== 64'd11) $display("FAIL bp_b_second: got %0h expected b", b_data); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_b_reopen: got %b expected 1", in_ready); else passed++;
      step();
      in_valid = 1'b0;
      total++; if (b_valid !== 1'b1) $display("FAIL bp_b_third_valid: got %b expected 1", b_valid); else passed++;
      total++; if (b_data !== 64'd12) $display("FAIL bp_b_third: got %0h expected c", b_data); else passed++;
      step();
      total++; if (b_valid !== 1'b0) $display("FAIL bp_b_empty: got %b expected 0", b_valid); else passed++;
      total++; if (a_data !== 64'd5) $display("FAIL bp_a_hold: got %0h expected 5", a_data); else passed++;
      a_ready = 1'b1;
      step();
      total++; if (a_valid !== 1'b0) $display("FAIL bp_a_drained: got %b expected 0", a_valid); else passed++;
      a_ready = 1'b0; b_ready = 1'b0;
   endtask

   task automatic test_illegal();
      in_valid = 1'b1; in_sel = 2'b01; in_data = 64'hDEAD;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL ill_ready_01: got %b expected 1", in_ready); else passed++;
      step();
      in_sel = 2'b10;
      total++; if (sel_err !== 1'b1) $display("FAIL ill_err_1: got %b expected 1", sel_err); else passed++;
      total++; if (drop_cnt !== 8'd1) $display("FAIL ill_cnt_1: got %0d expected 1", drop_cnt); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL ill_ready_10: got %b expected 1", in_ready); else passed++;
      step();
      in_valid = 1'b0;
      total++; if (sel_err !== 1'b1) $display("FAIL ill_err_2: got %b expected 1", sel_err); else passed++;
      total++; if (drop_cnt !== 8'd2) $display("FAIL ill_cnt_2: got %0d expected 2", drop_cnt); else passed++;
      total++; if (a_valid !== 1'b0 || b_valid !== 1'b0)
         $display("FAIL ill_no_out: got a=%b b=%b expected a=0 b=0", a_valid, b_valid); else passed++;
      step();
      total++; if (sel_err !== 1'b0) $display("FAIL ill_err_clear: got %b expected 0", sel_err); else passed++;
      in_valid = 1'b1; in_sel = 2'b01;
      for (int i = 0; i < 300; i++) begin
         step();
         if (i == 252) begin
            total++; if (drop_cnt !== 8'd255) $display("FAIL ill_cnt_reach: got %0d expected 255", drop_cnt); else passed++;
         end
      end
      in_valid = 1'b0;
      step();
      total++; if (drop_cnt !== 8'd255) $display("FAIL ill_cnt_sat: got %0d expected 255", drop_cnt); else passed++;
   endtask

   task automatic test_mid_reset();
      a_ready = 1'b0; in_valid = 1'b1; in_sel = 2'b00; in_data = 64'd20;
      step();
      in_data = 64'd21;
      step();
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0) $display("FAIL mr_a_full: got %b expected 0", in_ready); else passed++;
      total++; if (a_data !== 64'd20) $display("FAIL mr_a_head: got %0h expected 14", a_data); else passed++;
      #2 reset_n = 1'b0;
      #1;
      total++; if (a_valid !== 1'b0) $display("FAIL mr_async_valid: got %b expected 0", a_valid); else passed++;
      total++; if (drop_cnt !== 8'd0) $display("FAIL mr_async_cnt: got %0d expected 0", drop_cnt); else passed++;
      step();
      #2 reset_n = 1'b1;
      step();
      a_ready = 1'b1; in_valid = 1'b1; in_sel = 2'b00; in_data = 64'd7;
      step();
      in_valid = 1'b0;
      total++; if (a_valid !== 1'b1) $display("FAIL mr_first_valid: got %b expected 1", a_valid); else passed++;
      total++; if (a_data !== 64'd7) $display("FAIL mr_first_data: got %0h expected 7", a_data); else passed++;
      step();
      total++; if (a_valid !== 1'b0) $display("FAIL mr_drained: got %b expected 0", a_valid); else passed++;
      a_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_route_a();
      test_route_b();
      test_backpressure();
      test_illegal();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
